fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 7 +
 rtl/fetch_stage_pc_reg.sv | 16 +
 rtl/fetch_stage.sv | 63 ++++++
 tb/tb_fetch_stage.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: FSM state type and PC/bubble constants shared by the fetch stage
package fetch_stage_pkg;
    typedef enum logic {BOOT, RUN} state_t;
    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// fetch_stage_pc_reg: program counter with load, hold and sequential increment
module fetch_stage_pc_reg import fetch_stage_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_hold,
    input  logic [31:0] i_load_pc,
    output logic [31:0] o_pc
);
    logic [31:0] r_pc;
    always_ff @(posedge i_clk)
        r_pc <= !i_rst_n ? RESET_PC : i_load ? i_load_pc : i_hold ? r_pc : r_pc + PC_INC;
    assign o_pc = r_pc;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing with redirect/stall priority and the IF/ID register
module fetch_stage import fetch_stage_pkg::*; #(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_instr_out,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_pc_plus4_out,
    output logic        o_valid_out,
    output logic        o_misalign_out
);
    state_t      r_state;
    logic [31:0] r_instr, r_pc_out, r_pc4;
    logic        r_valid, r_mis;
    logic [31:0] w_pc;
    logic        w_run, w_redir;
    assign w_run   = r_state == RUN;
    assign w_redir = w_run && i_redirect;
    fetch_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (w_redir),
        .i_hold    (!w_run || i_stall),
        .i_load_pc ({i_redirect_pc[31:2], 2'b00}),
        .o_pc      (w_pc)
    );
    // BOOT and redirect both insert a bubble; a plain stall freezes the whole entry
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= BOOT;
            r_instr  <= NOP_INSTR;
            r_pc_out <= '0;
            r_pc4    <= '0;
            r_valid  <= 1'b0;
            r_mis    <= 1'b0;
        end else if (!w_run || i_redirect) begin
            r_state  <= RUN;
            r_instr  <= NOP_INSTR;
            r_pc_out <= '0;
            r_pc4    <= '0;
            r_valid  <= 1'b0;
            r_mis    <= r_mis || (w_run && |i_redirect_pc[1:0]);
        end else if (!i_stall) begin
            r_instr  <= i_imem_data;
            r_pc_out <= w_pc;
            r_pc4    <= w_pc + PC_INC;
            r_valid  <= 1'b1;
        end
    end
    assign o_imem_addr    = w_pc;
    assign o_instr_out    = r_instr;
    assign o_pc_out       = r_pc_out;
    assign o_pc_plus4_out = r_pc4;
    assign o_valid_out    = r_valid;
    assign o_misalign_out = r_mis;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against a behavioural model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n, stall, redirect;
    logic [31:0] redirect_pc, imem_data, key;
    logic [31:0] imem_addr, instr_out, pc_out, pc4_out;
    logic        valid_out, mis_out;
    logic        w_rst_n, w_zero;
    logic [31:0] w_zero32, w_imem_data, w_imem_addr, w_instr, w_pc, w_pc4;
    logic        w_valid, w_mis;
    int n_vec = 0, n_bad = 0;
    logic [31:0] m_pc, m_instr, m_pco, m_pc4;
    logic        m_boot, m_valid, m_mis;

    always #5 clk = ~clk;

    always_comb imem_data   = (imem_addr + 32'h100) ^ key;
    always_comb w_imem_data = w_imem_addr + 32'h100;

    fetch_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .i_imem_data(imem_data), .o_imem_addr(imem_addr),
        .o_instr_out(instr_out), .o_pc_out(pc_out), .o_pc_plus4_out(pc4_out),
        .o_valid_out(valid_out), .o_misalign_out(mis_out)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0013)) dut_wrap (
        .i_clk(clk), .i_rst_n(w_rst_n), .i_stall(w_zero), .i_redirect(w_zero),
        .i_redirect_pc(w_zero32), .i_imem_data(w_imem_data), .o_imem_addr(w_imem_addr),
        .o_instr_out(w_instr), .o_pc_out(w_pc), .o_pc_plus4_out(w_pc4),
        .o_valid_out(w_valid), .o_misalign_out(w_mis)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // what the next edge should produce, from the stated rules
    task automatic model_step();
        if (!rst_n) begin
            m_pc = 32'h0; m_boot = 1'b1; m_mis = 1'b0;
            m_instr = 32'h0; m_pco = 0; m_pc4 = 0; m_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_instr = 32'h0; m_pco = 0; m_pc4 = 0; m_valid = 1'b0;
        end else if (redirect) begin
            m_pc = redirect_pc - (redirect_pc % 4);
            if (redirect_pc % 4 != 0) m_mis = 1'b1;
            m_instr = 32'h0; m_pco = 0; m_pc4 = 0; m_valid = 1'b0;
        end else if (!stall) begin
            m_instr = (m_pc + 32'h100) ^ key;
            m_pco = m_pc;
            m_pc4 = m_pc + 4;
            m_valid = 1'b1;
            m_pc = m_pc + 4;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk); #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_out", instr_out, m_instr);
        chk("pc_out", pc_out, m_pco);
        chk("pc_plus4_out", pc4_out, m_pc4);
        chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
        chk("misalign_out", {31'b0, mis_out}, {31'b0, m_mis});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 0; key = 0;
        w_rst_n = 1'b0; w_zero = 1'b0; w_zero32 = 0;
        m_pc = 0; m_boot = 1; m_instr = 0; m_pco = 0; m_pc4 = 0; m_valid = 0; m_mis = 0;
        cyc();
        chk("rst_valid", {31'b0, valid_out}, 32'h0);
        chk("wrap_rst_instr", w_instr, 32'h13);
        chk("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFF8);
        rst_n = 1'b1; w_rst_n = 1'b1;
        cyc();
        chk("boot_bubble", {31'b0, valid_out}, 32'h0);
        chk("wrap_boot_instr", w_instr, 32'h13);
        chk("wrap_boot_valid", {31'b0, w_valid}, 32'h0);
        cyc();
        chk("fetch0_instr", instr_out, 32'h100);
        chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        chk("wrap_pc4_0", w_pc4, 32'hFFFF_FFFC);
        cyc();
        chk("fetch1_instr", instr_out, 32'h104);
        chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4_1", w_pc4, 32'h0);
        chk("wrap_addr_wrap", w_imem_addr, 32'h0);
        chk("wrap_instr1", w_instr, 32'h0000_00FC);
        w_rst_n = 1'b0;
        cyc();
        chk("fetch2_pc", pc_out, 32'h8);
        chk("fetch2_addr", imem_addr, 32'hC);
        stall = 1'b1;
        repeat (3) cyc();
        chk("stall_pc", pc_out, 32'h8);
        chk("stall_instr", instr_out, 32'h108);
        chk("stall_addr", imem_addr, 32'hC);
        chk("stall_valid", {31'b0, valid_out}, 32'h1);
        stall = 1'b0;
        cyc();
        chk("resume_pc", pc_out, 32'hC);
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        cyc();
        chk("redir_valid", {31'b0, valid_out}, 32'h0);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_pc_out", pc_out, 32'h0);
        redirect = 1'b0; stall = 1'b0;
        cyc();
        chk("redir_target", pc_out, 32'h40);
        redirect = 1'b1; redirect_pc = 32'h43;
        cyc();
        chk("mis_addr", imem_addr, 32'h40);
        chk("mis_set", {31'b0, mis_out}, 32'h1);
        redirect_pc = 32'h80;
        cyc();
        chk("mis_sticky", {31'b0, mis_out}, 32'h1);
        redirect = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst_n       = ($urandom_range(0, 39) != 0);
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 9) < 2);
            redirect_pc = $urandom;
            if ($urandom_range(0, 1) != 0) redirect_pc[1:0] = 2'b00;
            key         = $urandom;
            cyc();
        end
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; key = 0;
        cyc();
        rst_n = 1'b1;
        repeat (7) cyc();
        chk("pre_rst_pc", pc_out, 32'h14);
        stall = 1'b1;
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("midstall_rst_pc", pc_out, 32'h0);
        chk("midstall_rst_addr", imem_addr, 32'h0);
        rst_n = 1'b1; stall = 1'b0;
        cyc();
        chk("restart_bubble", {31'b0, valid_out}, 32'h0);
        cyc();
        chk("restart_pc", pc_out, 32'h0);
        chk("restart_valid", {31'b0, valid_out}, 32'h1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
